stage_seq_tracker: RTL

STAGE_SEQ_TRACKER -- requirements
Module: stage_seq_tracker

---
 rtl/stage_seq_tracker.sv | 99 +++++++++
 1 files changed

// File: rtl/stage_seq_tracker.sv
// Collection-window tracker: arms on request, gathers sticky per-stage done flags,
// and reports completion, timeout failure or in-progress as registered state decodes.
module stage_seq_tracker #(
    parameter int unsigned NSTAGES = 12,
    parameter int unsigned TMO_W   = 8
) (
    input  logic               CK,
    input  logic               rst_n,
    input  logic               en,
    input  logic               arm,
    input  logic [NSTAGES-1:0] stage_done,
    input  logic               force_req,
    input  logic               force_block,
    input  logic [TMO_W-1:0]   tmo_limit,
    input  logic               ack,
    output logic [NSTAGES-1:0] captured,
    output logic               complete,
    output logic               fail,
    output logic               busy
);

    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_COLLECT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               force_ok;
    logic [NSTAGES-1:0] cap_merge;
    logic               all_done;
    logic               tmo_hit;
    logic               complete_nxt;
    logic               fail_nxt;
    logic               busy_nxt;

    assign force_ok  = force_req & ~force_block;
    // Include this cycle's inputs so the final done flag completes on its own edge.
    assign cap_merge = captured | stage_done | {NSTAGES{force_ok}};
    assign all_done  = &cap_merge;
    assign tmo_hit   = (tmo_limit != '0) && ((tmo_cnt + TMO_ONE) == tmo_limit);

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            complete <= 1'b0;
            fail     <= 1'b0;
            busy     <= 1'b0;
        end else if (en) begin
            state    <= state_nxt;
            complete <= complete_nxt;
            fail     <= fail_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (arm) state_nxt = S_ARMED;
            S_ARMED:   state_nxt = S_COLLECT;
            S_COLLECT: begin
                if (all_done)     state_nxt = S_DONE;
                else if (tmo_hit) state_nxt = S_FAIL;
            end
            S_DONE,
            S_FAIL:    if (ack) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        complete_nxt = (state_nxt == S_DONE);
        fail_nxt     = (state_nxt == S_FAIL);
        busy_nxt     = (state_nxt == S_ARMED) || (state_nxt == S_COLLECT);
    end

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            captured <= '0;
            tmo_cnt  <= '0;
        end else if (en) begin
            if (state == S_IDLE && arm) begin
                captured <= '0;
                tmo_cnt  <= '0;
            end else if (state == S_COLLECT) begin
                captured <= cap_merge;
                if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_ONE;
            end
        end
    end

endmodule
